// File: rtl/aoi_pipe_lanes.sv
// aoi_pipe_lanes
//   WIDTH-lane bitwise AND-OR / NOR pipeline:
//     x = (a & b) | c,  y = ~(x | d)
//   Stage 1 registers the operands, stage 2 registers x/y, and stages
//   3..STAGES carry x/y forward. Every stage has its own valid bit and loads
//   whenever it is empty or its content moves on. Empty slots therefore
//   collapse under a stall, and the input only back-pressures once every
//   stage holds a beat.
//
//   Optional feature macro: AOI_PIPE_CNT_EN adds a 16-bit beat_count output.
//   It counts transfers out and wraps from 16'hFFFF to 0.
//
// Ports
//   clk         in   1      clock, rising edge
//   reset       in   1      synchronous active-high reset
//   valid_in    in   1      a/b/c/d carry a beat
//   ready_in    out  1      block accepts a beat this cycle
//   a,b,c,d     in   WIDTH  operand lanes
//   valid_out   out  1      x/y carry a result
//   ready_out   in   1      downstream takes the result this cycle
//   x,y         out  WIDTH  result lanes
//   beat_count  out  16     results delivered (AOI_PIPE_CNT_EN only)
module aoi_pipe_lanes #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
`ifdef AOI_PIPE_CNT_EN
  ,
  output logic [15:0]      beat_count
`endif
);

  logic [STAGES:1]  v;
  logic [STAGES:1]  load;
  logic             carry;
  logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic [WIDTH-1:0] x_q [2:STAGES];
  logic [WIDTH-1:0] y_q [2:STAGES];
  logic [WIDTH-1:0] x_c, y_c;

  // A stage may load when it, or any stage downstream of it, is empty, or
  // when the output is being taken. Walking from the output backwards gives
  // load[i] = !v[i] | load[i+1]. That is equivalent to !v[i] | (v[i] & load[i+1]).
  always_comb begin
    load  = '0;
    carry = ready_out;
    for (int i = STAGES; i >= 1; i--) begin
      carry   = !v[i] | carry;
      load[i] = carry;
    end
  end

  assign x_c = (a_q & b_q) | c_q;
  assign y_c = ~(x_c | d_q);

  assign ready_in  = load[1] & !reset;
  assign valid_out = v[STAGES] & !reset;
  assign x         = x_q[STAGES];
  assign y         = y_q[STAGES];

  // Data registers only capture a valid beat. A bubble therefore leaves the
  // last delivered result on x/y instead of shuffling stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      v   <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
      for (int i = 2; i <= STAGES; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      if (load[1]) begin
        v[1] <= valid_in;
        if (valid_in) begin
          a_q <= a;
          b_q <= b;
          c_q <= c;
          d_q <= d;
        end
      end
      if (load[2]) begin
        v[2] <= v[1];
        if (v[1]) begin
          x_q[2] <= x_c;
          y_q[2] <= y_c;
        end
      end
      for (int i = 3; i <= STAGES; i++) begin
        if (load[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            x_q[i] <= x_q[i-1];
            y_q[i] <= y_q[i-1];
          end
        end
      end
    end
  end

`ifdef AOI_PIPE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_count <= '0;
    end else if (valid_out && ready_out) begin
      beat_count <= beat_count + 16'd1;
    end
  end
`else
  // Delivered-beat counter is not built in this configuration.
`endif

endmodule

// File: tb/tb_aoi_pipe_lanes.sv
module tb_aoi_pipe_lanes;
  localparam int W = 4;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid_in = 1'b0;
  logic         ready_out = 1'b1;
  logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
  logic         ready_in, valid_out;
  logic [W-1:0] x, y;
`ifdef AOI_PIPE_CNT_EN
  logic [15:0]  beat_count;
`endif

  always #5 clk = ~clk;

  aoi_pipe_lanes #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .x         (x),
    .y         (y)
`ifdef AOI_PIPE_CNT_EN
    ,
    .beat_count(beat_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] f_x(input logic [W-1:0] a_, b_, c_);
    return (a_ & b_) | c_;
  endfunction

  function automatic logic [W-1:0] f_y(input logic [W-1:0] a_, b_, c_, d_);
    return ~(((a_ & b_) | c_) | d_);
  endfunction

  // Reference model: a queue of in-flight beats, oldest first, each with the
  // stage position it occupies. A beat steps forward when the slot ahead is
  // free after the older beat has moved. The oldest beat leaves from the
  // last stage when ready_out is high.
  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           pos;
  } beat_t;

  beat_t        q[$];
  beat_t        nq[$];
  beat_t        bt, nb;
  int           ahead;
  bit           acc;
  logic [W-1:0] last_x = '0, last_y = '0;
  logic [15:0]  mcnt = '0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      last_x = '0;
      last_y = '0;
      mcnt   = '0;
    end else begin
      acc = valid_in && (ready_out || q.size() < S);
      nq.delete();
      ahead = S + 2;
      for (int i = 0; i < q.size(); i++) begin
        bt = q[i];
        if (i == 0 && bt.pos == S && ready_out) begin
          mcnt = mcnt + 16'd1;
          continue;
        end
        if (bt.pos < S && ahead > bt.pos + 1) bt.pos = bt.pos + 1;
        ahead = bt.pos;
        if (bt.pos == S) begin
          last_x = bt.x;
          last_y = bt.y;
        end
        nq.push_back(bt);
      end
      if (acc) begin
        nb.x   = f_x(a, b, c);
        nb.y   = f_y(a, b, c, d);
        nb.pos = 1;
        nq.push_back(nb);
      end
      q = nq;
    end
  end

  logic         pv = 1'b0, pr = 1'b0;
  logic [W-1:0] px = '0, py = '0;
  bit           ev;

  always @(negedge clk) begin
    if (chk_en) begin
      ev = !reset && q.size() > 0 && q[0].pos == S;
      chk("ready_in", ready_in, !reset && (ready_out || q.size() < S));
      chk("valid_out", valid_out, ev);
      if (ev) begin
        chk("x", x, q[0].x);
        chk("y", y, q[0].y);
      end else begin
        chk("x_idle", x, last_x);
        chk("y_idle", y, last_y);
      end
      if (pv && !pr && !reset) begin
        chk("stall_valid", valid_out, 1);
        chk("stall_x", x, px);
        chk("stall_y", y, py);
      end
`ifdef AOI_PIPE_CNT_EN
      chk("beat_count", beat_count, mcnt);
`endif
      pv = valid_out;
      pr = ready_out;
      px = x;
      py = y;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int n_acc;

  initial begin
    cyc();
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready_in", ready_in, 1);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);

    // Single beat, latency S with no stall.
    cyc();
    valid_in = 1'b1; a = 4'hF; b = 4'h3; c = 4'h4; d = 4'h0;
    cyc();
    valid_in = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    chk("lat_early_valid", valid_out, 0);
    cyc();
    @(negedge clk);
    chk("lat_valid", valid_out, 1);
    chk("lat_x", x, 4'h7);
    chk("lat_y", y, 4'h8);
    cyc();

    // Every a/b/c/d combination in every lane, back to back.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < W; j++) begin
        logic [3:0] cmb;
        cmb  = 4'(i + j);
        a[j] = cmb[3];
        b[j] = cmb[2];
        c[j] = cmb[1];
        d[j] = cmb[0];
      end
      valid_in = 1'b1;
      cyc();
    end
    valid_in = 1'b0;
    repeat (S + 2) cyc();

    // Fill under stall, then drain without gaps.
    ready_out = 1'b0;
    n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      valid_in = 1'b1;
      a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
      @(negedge clk);
      if (ready_in) n_acc++;
      cyc();
    end
    @(negedge clk);
    chk("full_accepts", n_acc, 4);
    chk("full_ready_in", ready_in, 0);
    cyc();
    valid_in  = 1'b0;
    ready_out = 1'b1;
    for (int k = 0; k < S; k++) begin
      @(negedge clk);
      chk("drain_valid", valid_out, 1);
      cyc();
    end
    repeat (4) cyc();

    // Alternating input with random backpressure.
    for (int i = 0; i < 300; i++) begin
      valid_in  = (i % 2) == 0;
      a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
      ready_out = 1'($urandom_range(0, 1));
      cyc();
    end
    valid_in  = 1'b0;
    ready_out = 1'b1;
    repeat (S + 4) cyc();

    // Reset with three beats in flight.
    ready_out = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid_in = 1'b1;
      a = W'($urandom); b = W'($urandom); c = 4'hF; d = W'($urandom);
      cyc();
    end
    reset = 1'b1;
    @(negedge clk);
    chk("inrst_ready_in", ready_in, 0);
    chk("inrst_valid_out", valid_out, 0);
    cyc();
    reset     = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    @(negedge clk);
    chk("flush_valid_out", valid_out, 0);
    chk("flush_x", x, 0);
    chk("flush_y", y, 0);
    chk("flush_ready_in", ready_in, 1);
    repeat (S + 4) cyc();

`ifdef AOI_PIPE_CNT_EN
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("cnt_after_rst", beat_count, 0);
    valid_in  = 1'b1;
    ready_out = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      a = W'(i); b = W'(i >> 4); c = W'(i >> 8); d = W'(i >> 12);
      cyc();
    end
    valid_in = 1'b0;
    repeat (S + 2) cyc();
    @(negedge clk);
    chk("cnt_wrap", beat_count, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("cnt_rst", beat_count, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
